// File: rtl/phase_scanner.sv
// Per-voice phase accumulator bank: on each tick, walks voices 0..7, adds the
// RAM-supplied increment to each voice's phase and streams the results.
module phase_scanner #(
    parameter int NVOICE = 8,
    parameter int WIDTH  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic [NVOICE-1:0]         gate,
    input  logic [WIDTH-1:0]          ram_data,
    output logic [$clog2(NVOICE)-1:0] ram_sel,
    output logic [WIDTH-1:0]          phase_out,
    output logic [$clog2(NVOICE)-1:0] voice_out,
    output logic                      phase_valid,
    output logic                      frame_done,
    output logic                      busy,
    output logic                      overrun
);
    localparam int SELW = $clog2(NVOICE);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                       state_q, state_d;
    logic [SELW-1:0]              vidx_q, vidx_d;
    logic [WIDTH-1:0]             phase_out_q, phase_out_d;
    logic [SELW-1:0]              voice_out_q, voice_out_d;
    logic                         phase_valid_q, phase_valid_d;
    logic                         frame_done_q, frame_done_d;
    logic                         overrun_q, overrun_d;

    // Candidate new phase for every voice; only the one at vidx is committed.
    logic [NVOICE-1:0][WIDTH-1:0] cand_phase;

    genvar gi;
    generate
        for (gi = 0; gi < NVOICE; gi++) begin : g_voice
            logic [WIDTH-1:0] phase_q, phase_d;
            logic             hit;

            assign hit            = (state_q == SCAN) && (vidx_q == SELW'(gi));
            assign cand_phase[gi] = gate[gi] ? (phase_q + ram_data) : '0;

            always_comb begin
                phase_d = phase_q;
                if (hit) begin
                    phase_d = cand_phase[gi];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    phase_q <= '0;
                end else begin
                    phase_q <= phase_d;
                end
            end
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        vidx_d        = vidx_q;
        phase_out_d   = phase_out_q;
        voice_out_d   = voice_out_q;
        phase_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        overrun_d     = overrun_q;
        ram_sel       = '0;
        busy          = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d = SCAN;
                    vidx_d  = '0;
                end
            end
            SCAN: begin
                ram_sel       = vidx_q;
                busy          = 1'b1;
                phase_out_d   = cand_phase[vidx_q];
                voice_out_d   = vidx_q;
                phase_valid_d = 1'b1;
                // A tick during a scan is dropped, but remembered until reset.
                if (tick) begin
                    overrun_d = 1'b1;
                end
                if (vidx_q == SELW'(NVOICE - 1)) begin
                    frame_done_d = 1'b1;
                    state_d      = IDLE;
                    vidx_d       = '0;
                end else begin
                    vidx_d = vidx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            vidx_q        <= '0;
            phase_out_q   <= '0;
            voice_out_q   <= '0;
            phase_valid_q <= 1'b0;
            frame_done_q  <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            vidx_q        <= vidx_d;
            phase_out_q   <= phase_out_d;
            voice_out_q   <= voice_out_d;
            phase_valid_q <= phase_valid_d;
            frame_done_q  <= frame_done_d;
            overrun_q     <= overrun_d;
        end
    end

    assign phase_out   = phase_out_q;
    assign voice_out   = voice_out_q;
    assign phase_valid = phase_valid_q;
    assign frame_done  = frame_done_q;
    assign overrun     = overrun_q;

endmodule
